// File: rtl/wb_spi_master_top.sv
// Wishbone slave to SPI master (mode 0, MSB first) bridge for serial EEPROMs.
// Byte commands are queued in a small FIFO and carry START/STOP/READ framing flags.
module wb_spi_master_top #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  DIV_RESET  = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_addr,
  input  logic        wb_we,
  input  logic        wb_stb,
  input  logic        wb_cyc,
  input  logic [31:0] wb_dout,
  output logic [31:0] wb_din,
  output logic        wb_ack,
  output logic        spi_mosi,
  output logic        spi_sck,
  output logic        spi_ss,
  input  logic        spi_miso,
  output logic        irq
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETUP     = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI  = 3'd2;
  localparam logic [2:0] ST_SHIFT_LO  = 3'd3;
  localparam logic [2:0] ST_STOP_WAIT = 3'd4;
  localparam logic [2:0] ST_CS_HOLD   = 3'd5;

  logic [10:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty;
  logic [10:0]   fifo_head;

  logic [2:0]  state;
  logic [7:0]  timer, div, div_cur;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sh, rx_sh, rx_byte;
  logic        rx_valid, cmd_stop, cmd_read;

  logic [7:0]  addr;
  logic        sel, is_cmd_wr, accept, push, pop, busy;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{wb_addr[31:8], wb_dout[31:11]};

  assign addr       = wb_addr[7:0];
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  // A command write against a full FIFO stalls the handshake instead of dropping data.
  assign sel       = wb_stb & wb_cyc & ~wb_ack;
  assign is_cmd_wr = wb_we && (addr == 8'h10);
  assign accept    = sel && !(is_cmd_wr && fifo_full);
  assign push      = accept && is_cmd_wr;
  assign pop       = (state == ST_IDLE) && !fifo_empty;

  always_comb begin
    rd_data = '0;
    case (addr)
      8'h00:   rd_data = {29'b0, fifo_full, rx_valid, busy};
      8'h10:   rd_data = {24'b0, rx_byte};
      8'h20:   rd_data = {24'b0, div};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wb_dout[10:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_ack   <= 1'b0;
      wb_din   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      div      <= DIV_RESET;
      div_cur  <= DIV_RESET;
      state    <= ST_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      cmd_stop <= 1'b0;
      cmd_read <= 1'b0;
      irq      <= 1'b0;
      spi_sck  <= 1'b0;
      spi_ss   <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      wb_ack <= accept;
      wb_din <= (accept && !wb_we) ? rd_data : '0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (accept && wb_we && addr == 8'h20) div <= wb_dout[7:0];
      // Cleared here first so a completion later in this block takes priority.
      if (accept && !wb_we && addr == 8'h10) begin
        rx_valid <= 1'b0;
        irq      <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            tx_sh    <= fifo_head[7:0];
            spi_mosi <= fifo_head[7];
            cmd_stop <= fifo_head[9];
            cmd_read <= fifo_head[10];
            if (fifo_head[8]) spi_ss <= 1'b0;
            div_cur  <= div;
            timer    <= div;
            bit_cnt  <= '0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (timer == '0) begin
            spi_sck <= 1'b1;
            rx_sh   <= {rx_sh[6:0], spi_miso};
            timer   <= div_cur;
            state   <= ST_SHIFT_HI;
          end else timer <= timer - 1'b1;
        end
        ST_SHIFT_HI: begin
          if (timer == '0) begin
            spi_sck  <= 1'b0;
            tx_sh    <= {tx_sh[6:0], 1'b0};
            spi_mosi <= tx_sh[6];
            timer    <= div_cur;
            state    <= ST_SHIFT_LO;
            if (bit_cnt == 3'd7 && cmd_read) begin
              rx_byte  <= rx_sh;
              rx_valid <= 1'b1;
              irq      <= 1'b1;
            end
          end else timer <= timer - 1'b1;
        end
        ST_SHIFT_LO: begin
          if (timer == '0) begin
            if (bit_cnt == 3'd7) begin
              if (cmd_stop) begin
                timer <= div_cur;
                state <= ST_STOP_WAIT;
              end else state <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              spi_sck <= 1'b1;
              rx_sh   <= {rx_sh[6:0], spi_miso};
              timer   <= div_cur;
              state   <= ST_SHIFT_HI;
            end
          end else timer <= timer - 1'b1;
        end
        ST_STOP_WAIT: begin
          if (timer == '0) begin
            spi_ss <= 1'b1;
            timer  <= div_cur;
            state  <= ST_CS_HOLD;
          end else timer <= timer - 1'b1;
        end
        ST_CS_HOLD: begin
          if (timer == '0) state <= ST_IDLE;
          else timer <= timer - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_spi_master_top.sv
// Randomised self-checking bench: bus tasks, an SPI slave/monitor sampled on clk
// falling edges, and expected bytes derived directly from the queued commands.
`timescale 1ns/1ps
module tb_wb_spi_master_top;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] wb_addr = '0;
  logic        wb_we = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0;
  logic [31:0] wb_dout = '0;
  logic [31:0] wb_din;
  logic        wb_ack, spi_mosi, spi_sck, spi_ss, irq;
  logic        spi_miso = 1'b0;

  int unsigned vectors = 0, miscompares = 0;

  wb_spi_master_top #(.FIFO_DEPTH(4), .DIV_RESET(8'd4)) dut (
    .clk(clk), .rst(rst), .wb_addr(wb_addr), .wb_we(wb_we), .wb_stb(wb_stb),
    .wb_cyc(wb_cyc), .wb_dout(wb_dout), .wb_din(wb_din), .wb_ack(wb_ack),
    .spi_mosi(spi_mosi), .spi_sck(spi_sck), .spi_ss(spi_ss),
    .spi_miso(spi_miso), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  // ---------------- SPI slave and monitor ----------------
  logic [7:0]  mosi_q[$];
  logic [7:0]  sl_q[$];
  logic [7:0]  sl_byte = '0, mon_sh = '0;
  int unsigned sl_idx = 0, mon_cnt = 0;
  bit          sl_loaded = 0;
  logic        prev_sck = 1'b0, prev_ss = 1'b1;
  int unsigned rises, rise_ss_hi, ss_falls, ss_rises;
  int unsigned hi_cnt, since_rise, hi_min, hi_max, per_min, per_max;

  always @(negedge clk) begin
    if (!rst) begin
      mon_cnt = 0; sl_idx = 0; sl_loaded = 0; sl_q.delete();
      prev_sck = 1'b0; prev_ss = 1'b1; spi_miso = 1'b0;
    end else begin
      since_rise++;
      if (spi_sck && !prev_sck) begin
        rises++;
        if (spi_ss) rise_ss_hi++;
        if (mon_cnt != 0) begin
          if (since_rise < per_min) per_min = since_rise;
          if (since_rise > per_max) per_max = since_rise;
        end
        since_rise = 0;
        hi_cnt = 1;
        mon_sh = {mon_sh[6:0], spi_mosi};
        mon_cnt++;
        if (mon_cnt == 8) begin
          mosi_q.push_back(mon_sh);
          mon_cnt = 0;
        end
      end else if (spi_sck) hi_cnt++;
      if (!spi_sck && prev_sck) begin
        if (hi_cnt < hi_min) hi_min = hi_cnt;
        if (hi_cnt > hi_max) hi_max = hi_cnt;
        sl_idx++;
        if (sl_idx == 8) begin sl_idx = 0; sl_loaded = 0; end
      end
      if (!spi_ss && prev_ss) ss_falls++;
      if (spi_ss && !prev_ss) ss_rises++;
      if (!sl_loaded && sl_q.size() > 0) begin
        sl_byte = sl_q.pop_front();
        sl_loaded = 1;
      end
      spi_miso = sl_loaded ? sl_byte[7 - sl_idx] : 1'b0;
      prev_sck = spi_sck;
      prev_ss  = spi_ss;
    end
  end

  task automatic clear_mon();
    mosi_q.delete();
    rises = 0; rise_ss_hi = 0; ss_falls = 0; ss_rises = 0;
    hi_min = 32'hFFFF_FFFF; hi_max = 0; per_min = 32'hFFFF_FFFF; per_max = 0;
  endtask

  // ---------------- Wishbone access ----------------
  task automatic wb_xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                         input bit hold, output logic [31:0] rdata, output int unsigned cyc,
                         output logic ack_after, output logic [31:0] din_after);
    logic [31:0] r;
    r = $urandom();
    wb_addr = {r[31:8], a};
    wb_we = we; wb_dout = d; wb_stb = 1'b1; wb_cyc = 1'b1;
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (wb_ack) break;
      if (cyc > 20000) begin
        vectors++; miscompares++;
        $display("FAIL ack_timeout: addr %h no ack after %0d cycles, required ack", a, cyc);
        break;
      end
    end
    rdata = wb_din;
    ack_after = 1'b0; din_after = '0;
    if (hold) begin
      @(posedge clk); #1;
      ack_after = wb_ack; din_after = wb_din;
    end
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd, dn; int unsigned c; logic ak;
    wb_xfer(1'b1, a, d, 0, rd, c, ak, dn);
  endtask

  task automatic wb_rd(input logic [7:0] a, output logic [31:0] rdata);
    logic [31:0] dn; int unsigned c; logic ak;
    wb_xfer(1'b0, a, 32'h0, 0, rdata, c, ak, dn);
  endtask

  task automatic wait_idle(input int unsigned budget, output logic [31:0] st);
    int unsigned n = 0, c; logic ak; logic [31:0] dn;
    do begin
      wb_xfer(1'b0, 8'h00, 32'h0, 0, st, c, ak, dn);
      n += c;
    end while (st[0] && n < budget);
    if (st[0]) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic wait_irq(input int unsigned budget);
    int unsigned n = 0;
    while (!irq && n < budget) begin @(posedge clk); #1; n++; end
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_wait: irq %b after %0d cycles, required 1", irq, n);
    end
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    vectors++; if (spi_ss !== 1'b1)  begin miscompares++; $display("FAIL rst_ss: got %b required 1", spi_ss); end
    vectors++; if (spi_sck !== 1'b0) begin miscompares++; $display("FAIL rst_sck: got %b required 0", spi_sck); end
    vectors++; if (spi_mosi !== 1'b0) begin miscompares++; $display("FAIL rst_mosi: got %b required 0", spi_mosi); end
    vectors++; if (irq !== 1'b0)     begin miscompares++; $display("FAIL rst_irq: got %b required 0", irq); end
    vectors++; if (wb_ack !== 1'b0)  begin miscompares++; $display("FAIL rst_ack: got %b required 0", wb_ack); end
    vectors++; if (wb_din !== 32'h0) begin miscompares++; $display("FAIL rst_din: got %h required 0", wb_din); end
    rst = 1'b1;
    wb_rd(8'h00, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL rst_status: got %h required 00000000", v); end
    wb_rd(8'h10, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL rst_data: got %h required 00000000", v); end
    wb_rd(8'h20, v);
    vectors++; if (v !== 32'h4) begin miscompares++; $display("FAIL rst_div: got %h required 00000004", v); end
    wb_rd(8'h44, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL unmapped_rd: got %h required 0", v); end
  endtask

  task automatic test_div_frame();
    logic [31:0] v;
    clear_mon();
    wb_wr(8'h20, 32'hFFFF_FFFF);
    wb_wr(8'h44, 32'h0000_0001);
    wb_rd(8'h20, v);
    vectors++; if (v !== 32'hFF) begin miscompares++; $display("FAIL div_readback: got %h required 000000ff", v); end
    sl_q.push_back(8'($urandom()));
    wb_wr(8'h10, 32'h306);
    wait_idle(12000, v);
    vectors++; if (mosi_q.size() != 1) begin miscompares++; $display("FAIL frame_nbytes: got %0d required 1", mosi_q.size()); end
    else begin
      vectors++; if (mosi_q[0] !== 8'h06) begin miscompares++; $display("FAIL frame_mosi: got %h required 06", mosi_q[0]); end
    end
    vectors++; if (rises != 8) begin miscompares++; $display("FAIL frame_sck_count: got %0d required 8", rises); end
    vectors++; if (hi_min != 256 || hi_max != 256) begin miscompares++; $display("FAIL sck_high: got %0d..%0d required 256", hi_min, hi_max); end
    vectors++; if (per_min != 512 || per_max != 512) begin miscompares++; $display("FAIL sck_period: got %0d..%0d required 512", per_min, per_max); end
    vectors++; if (rise_ss_hi != 0) begin miscompares++; $display("FAIL frame_ss_low: %0d rises with ss high, required 0", rise_ss_hi); end
    vectors++; if (spi_ss !== 1'b1 || ss_rises != 1) begin miscompares++; $display("FAIL frame_ss_end: ss %b rises %0d required 1/1", spi_ss, ss_rises); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL frame_irq: got %b required 0", irq); end
  endtask

  task automatic test_multi_byte();
    logic [31:0] v, rd, dn;
    logic [7:0]  exp_b [4];
    int unsigned c;
    logic ak;
    exp_b[0] = 8'h02; exp_b[1] = 8'hFE; exp_b[2] = 8'h0B; exp_b[3] = 8'hC3;
    wb_wr(8'h20, 32'($urandom_range(0, 3)));
    clear_mon();
    for (int i = 0; i < 4; i++) sl_q.push_back(8'($urandom()));
    wb_wr(8'h10, 32'h102);
    wb_xfer(1'b1, 8'h10, 32'h0FE, 1, rd, c, ak, dn);
    vectors++; if (ak !== 1'b0 || dn !== 32'h0) begin miscompares++; $display("FAIL held_stb: ack %b din %h required 0/0", ak, dn); end
    wb_wr(8'h10, 32'h00B);
    wait_idle(2000, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL multi_status: got %h required 00000000", v); end
    vectors++; if (spi_ss !== 1'b0 || ss_rises != 0 || ss_falls != 1) begin
      miscompares++; $display("FAIL multi_ss_held: ss %b rises %0d falls %0d required 0/0/1", spi_ss, ss_rises, ss_falls);
    end
    vectors++; if (rises != 24 || rise_ss_hi != 0) begin miscompares++; $display("FAIL multi_sck: rises %0d ss_hi %0d required 24/0", rises, rise_ss_hi); end
    wb_wr(8'h10, 32'h2C3);
    wait_idle(2000, v);
    vectors++; if (mosi_q.size() != 4) begin miscompares++; $display("FAIL multi_nbytes: got %0d required 4", mosi_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      vectors++; if (mosi_q[i] !== exp_b[i]) begin miscompares++; $display("FAIL multi_mosi[%0d]: got %h required %h", i, mosi_q[i], exp_b[i]); end
    end
    vectors++; if (spi_ss !== 1'b1 || irq !== 1'b0) begin miscompares++; $display("FAIL multi_close: ss %b irq %b required 1/0", spi_ss, irq); end
  endtask

  task automatic test_read();
    logic [31:0] v;
    logic [7:0]  exp_mosi[$];
    logic [7:0]  exp_rx, d;
    int unsigned nb;
    clear_mon();
    sl_q.push_back(8'($urandom()));
    sl_q.push_back(8'h00);
    wb_wr(8'h10, 32'h105);
    wb_wr(8'h10, 32'h600);
    wait_irq(2000);
    wb_rd(8'h00, v);
    vectors++; if (v[1] !== 1'b1) begin miscompares++; $display("FAIL read_rx_valid: status %h required bit1=1", v); end
    wb_rd(8'h10, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL read_data: got %h required 00000000", v); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL read_irq_clear: got %b required 0", irq); end
    wait_idle(2000, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL read_status_after: got %h required 00000000", v); end

    for (int r = 0; r < 5; r++) begin
      wb_wr(8'h20, 32'($urandom_range(0, 2)));
      clear_mon();
      exp_mosi.delete();
      nb = $urandom_range(1, 3);
      exp_rx = 8'h00;
      for (int i = 0; i < nb; i++) begin
        d = 8'($urandom());
        exp_mosi.push_back(d);
        exp_rx = 8'($urandom());
        sl_q.push_back(exp_rx);
        wb_wr(8'h10, {21'b0, (i == nb - 1) ? 2'b11 : 2'b00, (i == 0) ? 1'b1 : 1'b0, d});
      end
      wait_idle(3000, v);
      vectors++; if (v !== 32'h2 || irq !== 1'b1) begin miscompares++; $display("FAIL rnd_status[%0d]: status %h irq %b required 00000002/1", r, v, irq); end
      vectors++; if (mosi_q.size() != nb) begin miscompares++; $display("FAIL rnd_nbytes[%0d]: got %0d required %0d", r, mosi_q.size(), nb); end
      else for (int i = 0; i < nb; i++) begin
        vectors++; if (mosi_q[i] !== exp_mosi[i]) begin miscompares++; $display("FAIL rnd_mosi[%0d][%0d]: got %h required %h", r, i, mosi_q[i], exp_mosi[i]); end
      end
      wb_rd(8'h10, v);
      vectors++; if (v !== {24'b0, exp_rx}) begin miscompares++; $display("FAIL rnd_rx[%0d]: got %h required %h", r, v, exp_rx); end
      vectors++; if (irq !== 1'b0 || spi_ss !== 1'b1) begin miscompares++; $display("FAIL rnd_end[%0d]: irq %b ss %b required 0/1", r, irq, spi_ss); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] v, rd, dn;
    logic [10:0] cmds [6];
    int unsigned c;
    logic ak;
    cmds[0] = 11'h111; cmds[1] = 11'h022; cmds[2] = 11'h033;
    cmds[3] = 11'h044; cmds[4] = 11'h055; cmds[5] = 11'h266;
    wb_wr(8'h20, 32'hFF);
    clear_mon();
    for (int i = 0; i < 6; i++) sl_q.push_back(8'($urandom()));
    for (int i = 0; i < 6; i++) begin
      wb_xfer(1'b1, 8'h10, {21'b0, cmds[i]}, 1, rd, c, ak, dn);
      vectors++; if (ak !== 1'b0) begin miscompares++; $display("FAIL bp_ack_pulse[%0d]: ack after pulse %b required 0", i, ak); end
      if (i < 4) begin
        vectors++; if (c > 2) begin miscompares++; $display("FAIL bp_fast[%0d]: ack after %0d cycles required <=2", i, c); end
      end
      if (i == 5) begin
        vectors++; if (c < 256) begin miscompares++; $display("FAIL bp_stall: ack after %0d cycles required >=256", c); end
      end
    end
    wait_idle(40000, v);
    vectors++; if (mosi_q.size() != 6) begin miscompares++; $display("FAIL bp_nbytes: got %0d required 6", mosi_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      vectors++; if (mosi_q[i] !== cmds[i][7:0]) begin miscompares++; $display("FAIL bp_mosi[%0d]: got %h required %h", i, mosi_q[i], cmds[i][7:0]); end
    end
    vectors++; if (spi_ss !== 1'b1 || ss_falls != 1 || ss_rises != 1) begin
      miscompares++; $display("FAIL bp_frame: ss %b falls %0d rises %0d required 1/1/1", spi_ss, ss_falls, ss_rises);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int unsigned n = 0, r0;
    wb_wr(8'h20, 32'h3);
    clear_mon();
    for (int i = 0; i < 3; i++) sl_q.push_back(8'($urandom()));
    wb_wr(8'h10, 32'h1AA);
    wb_wr(8'h10, 32'h055);
    wb_wr(8'h10, 32'h066);
    while (spi_sck !== 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
    vectors++; if (spi_sck !== 1'b1 || spi_ss !== 1'b0) begin miscompares++; $display("FAIL mid_shift_reached: sck %b ss %b required 1/0", spi_sck, spi_ss); end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (spi_ss !== 1'b1 || spi_sck !== 1'b0) begin miscompares++; $display("FAIL mid_reset_outputs: ss %b sck %b required 1/0", spi_ss, spi_sck); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wb_rd(8'h00, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL mid_status: got %h required 00000000", v); end
    r0 = rises;
    repeat (100) @(posedge clk);
    #1;
    vectors++; if (rises != r0 || spi_ss !== 1'b1) begin miscompares++; $display("FAIL mid_fifo_empty: %0d new sck rises ss %b required 0/1", rises - r0, spi_ss); end
    wb_rd(8'h20, v);
    vectors++; if (v !== 32'h4) begin miscompares++; $display("FAIL mid_div_reset: got %h required 00000004", v); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_div_frame();
    test_multi_byte();
    test_read();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
